magnitude_scheduler: RTL and testbench

//  Sequences the multi-cycle magnitude unit for the Sobel stage. Queues signed

---
 rtl/magnitude_scheduler_if.sv | 37 +++
 rtl/magnitude_scheduler.sv | 156 +++++++++++++++
 tb/tb_magnitude_scheduler.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/magnitude_scheduler_if.sv
// Signal bundle between the Sobel gradient datapath, the magnitude unit and the pixel sink.
// timeout_err exists only when MAG_WATCHDOG_EN is defined.
interface magnitude_scheduler_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [10:0] in_gx;
    logic signed [10:0] in_gy;
    logic signed [10:0] mag_a;
    logic signed [10:0] mag_b;
    logic               mag_start;
    logic [7:0]         mag_result;
    logic               mag_done;
    logic               out_valid;
    logic               out_ready;
    logic [7:0]         out_pixel;
    logic               busy;
`ifdef MAG_WATCHDOG_EN
    logic               timeout_err;
`endif

    // master is the scheduler; slave is the surrounding datapath, unit and sink
    modport master (
        input  in_valid, in_gx, in_gy, mag_result, mag_done, out_ready,
        output in_ready, mag_a, mag_b, mag_start, out_valid, out_pixel, busy
`ifdef MAG_WATCHDOG_EN
        , output timeout_err
`endif
    );

    modport slave (
        output in_valid, in_gx, in_gy, mag_result, mag_done, out_ready,
        input  in_ready, mag_a, mag_b, mag_start, out_valid, out_pixel, busy
`ifdef MAG_WATCHDOG_EN
        , input timeout_err
`endif
    );
endinterface

// File: rtl/magnitude_scheduler.sv
// Queues (gx, gy) pairs and runs the multi-cycle magnitude unit one pair at a time.
// Optional WAIT watchdog enabled by defining MAG_WATCHDOG_EN.
//
// state  | meaning
// IDLE   | waiting for a queued pair and an empty output buffer
// LAUNCH | operands loaded, mag_start asserted for this cycle only
// WAIT   | magnitude unit running; result captured on mag_done
module magnitude_scheduler #(
    parameter int DEPTH       = 4,
    parameter int MAG_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    magnitude_scheduler_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    state_t        state;
    state_t        state_nxt;
    logic [21:0]   queue_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          done_hit;
    logic          timeout_hit;

    // in_ready comes from the registered count, so a same-cycle pop never opens a slot
    assign bus.in_ready  = (count != FULL_COUNT);
    assign push          = bus.in_valid && bus.in_ready;
    assign bus.mag_start = (state == LAUNCH);
    assign bus.busy      = (state != IDLE) || (count != '0) || bus.out_valid;

`ifdef MAG_WATCHDOG_EN
    localparam int TW = $clog2(MAG_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(MAG_TIMEOUT - 1);

    logic [TW-1:0] wait_timer;

    // down-counter reloaded outside WAIT, so it starts fresh on every entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_timer <= TIMER_LOAD;
        end else if (state != WAIT) begin
            wait_timer <= TIMER_LOAD;
        end else if (wait_timer != '0) begin
            wait_timer <= wait_timer - 1'b1;
        end
    end

    assign timeout_hit = (state == WAIT) && !bus.mag_done && (wait_timer == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.timeout_err <= 1'b0;
        end else if (timeout_hit) begin
            bus.timeout_err <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^MAG_TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        done_hit  = 1'b0;
        case (state)
            IDLE: begin
                // only one result may be outstanding; hold off while out_valid is up
                if ((count != '0) && !bus.out_valid) begin
                    pop       = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.mag_done || timeout_hit) begin
                    done_hit  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            queue_mem[wr_ptr] <= {bus.in_gx, bus.in_gy};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.mag_a     <= '0;
            bus.mag_b     <= '0;
            bus.out_valid <= 1'b0;
            bus.out_pixel <= '0;
        end else begin
            if (pop) begin
                bus.mag_a <= queue_mem[rd_ptr][21:11];
                bus.mag_b <= queue_mem[rd_ptr][10:0];
            end
            if (done_hit) begin
                bus.out_valid <= 1'b1;
                bus.out_pixel <= timeout_hit ? 8'hFF : bus.mag_result;
            end else if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_magnitude_scheduler.sv
// Self-checking bench for magnitude_scheduler: magnitude-unit model, pixel scoreboard,
// directed scenarios and a randomized run. Define MAG_WATCHDOG_EN to cover the watchdog.
module tb_magnitude_scheduler;
    localparam int DEPTH       = 4;
    localparam int MAG_TIMEOUT = 64;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    magnitude_scheduler_if bus();

    magnitude_scheduler #(.DEPTH(DEPTH), .MAG_TIMEOUT(MAG_TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]         exp_pix[$];
    logic signed [10:0] exp_a[$];
    logic signed [10:0] exp_b[$];
    logic [7:0]         pix_log[$];
    int                 n_out = 0;

    bit   unit_stall    = 0;
    bit   force_timeout = 0;
    bit   stray_done    = 0;
    bit   u_busy        = 0;
    bit   u_hang        = 0;
    bit   pushes_done   = 0;
    int   unit_lat      = 5;
    int   u_cnt         = 0;
    int   start_cnt     = 0;
    int   last_start_cyc = -1;
    int   done_cyc      = -1;
    logic [7:0] u_res;

    // reference magnitude: floor(sqrt(gx^2 + gy^2)) clipped to 255
    function automatic logic [7:0] ref_mag(input logic signed [10:0] a, input logic signed [10:0] b);
        int s;
        int r;
        s = int'(a) * int'(a) + int'(b) * int'(b);
        r = 0;
        while (((r + 1) * (r + 1) <= s) && (r < 255)) r++;
        return 8'(r);
    endfunction

    // magnitude unit model; also checks operands and single-cycle start
    initial begin
        logic signed [10:0] ea;
        logic signed [10:0] eb;
        bus.mag_done   = 1'b0;
        bus.mag_result = 8'h00;
        forever begin
            @(negedge clk);
            bus.mag_done = 1'b0;
            if (reset) begin
                u_busy = 0;
                u_hang = 0;
            end else if (stray_done) begin
                stray_done     = 0;
                bus.mag_done   = 1'b1;
                bus.mag_result = 8'hAA;
            end else if (bus.mag_start) begin
                n_checks++;
                if (u_busy && !u_hang) $display("FAIL mag_start_single: start while unit busy, cycle %0d", cyc);
                else n_pass++;
                n_checks++;
                if (exp_a.size() == 0) begin
                    $display("FAIL mag_start_unexpected: start with no pending pair, cycle %0d", cyc);
                end else begin
                    ea = exp_a.pop_front();
                    eb = exp_b.pop_front();
                    if (bus.mag_a !== ea || bus.mag_b !== eb)
                        $display("FAIL mag_operands: got a=%0d b=%0d, expected a=%0d b=%0d", bus.mag_a, bus.mag_b, ea, eb);
                    else n_pass++;
                end
                start_cnt++;
                last_start_cyc = cyc;
                u_busy = 1;
                u_hang = 0;
                u_cnt  = (unit_lat > 0) ? unit_lat : int'($urandom_range(1, 8));
                u_res  = ref_mag(bus.mag_a, bus.mag_b);
                if (force_timeout) begin
                    force_timeout = 0;
                    u_hang = 1;
                    if (exp_pix.size() > 0) exp_pix[0] = 8'hFF;
                end
            end else if (u_busy && !u_hang && !unit_stall) begin
                u_cnt--;
                if (u_cnt <= 0) begin
                    bus.mag_done   = 1'b1;
                    bus.mag_result = u_res;
                    u_busy   = 0;
                    done_cyc = cyc;
                end
            end
        end
    end

    // input/output monitor: records accepted pairs, scores delivered pixels
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                if (bus.in_valid && bus.in_ready) begin
                    exp_a.push_back(bus.in_gx);
                    exp_b.push_back(bus.in_gy);
                    exp_pix.push_back(ref_mag(bus.in_gx, bus.in_gy));
                end
                if (bus.out_valid && bus.out_ready) begin
                    n_checks++;
                    n_out++;
                    pix_log.push_back(bus.out_pixel);
                    if (exp_pix.size() == 0) begin
                        $display("FAIL pixel_unexpected: got %0d with nothing expected", bus.out_pixel);
                    end else begin
                        e = exp_pix.pop_front();
                        if (bus.out_pixel !== e) $display("FAIL pixel_order: got %0d, expected %0d", bus.out_pixel, e);
                        else n_pass++;
                    end
                end
            end
        end
    end

    task automatic push(input logic signed [10:0] gx, input logic signed [10:0] gy, output int acc, output bit ok);
        ok  = 0;
        acc = -1;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_gx    = gx;
        bus.in_gy    = gy;
        for (int i = 0; i < 200; i++) begin
            if (bus.in_ready) begin
                ok  = 1;
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #2;
            if (exp_pix.size() == 0 && exp_a.size() == 0 && !bus.busy) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.mag_start !== 1'b0 || bus.busy !== 1'b0 ||
            bus.mag_a !== 11'sd0 || bus.mag_b !== 11'sd0 || bus.out_pixel !== 8'h00)
            $display("FAIL reset_outputs: out_valid=%b mag_start=%b busy=%b a=%0d b=%0d pixel=%0d, expected all 0",
                     bus.out_valid, bus.mag_start, bus.busy, bus.mag_a, bus.mag_b, bus.out_pixel);
        else n_pass++;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL reset_release: in_ready=%b busy=%b, expected 1 and 0", bus.in_ready, bus.busy);
        else n_pass++;
    endtask

    task automatic test_single();
        bit ok;
        int acc;
        int t;
        int s0;
        unit_lat      = 5;
        bus.out_ready = 1'b0;
        s0 = start_cnt;
        push(11'sd3, 11'sd4, acc, ok);
        t = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                t = cyc;
                break;
            end
        end
        n_checks++;
        if (!ok || t < 0) $display("FAIL single_timeout: accepted=%0d out_valid_cycle=%0d", ok, t);
        else n_pass++;
        n_checks++;
        if (last_start_cyc !== acc + 2) $display("FAIL single_start_latency: start at %0d, expected %0d", last_start_cyc, acc + 2);
        else n_pass++;
        n_checks++;
        if (t !== done_cyc + 1) $display("FAIL single_done_latency: out_valid at %0d, expected %0d", t, done_cyc + 1);
        else n_pass++;
        n_checks++;
        if (bus.out_pixel !== 8'd5 || bus.mag_a !== 11'sd3 || bus.mag_b !== 11'sd4 || start_cnt - s0 !== 1)
            $display("FAIL single_result: pixel=%0d a=%0d b=%0d starts=%0d, expected 5 3 4 1",
                     bus.out_pixel, bus.mag_a, bus.mag_b, start_cnt - s0);
        else n_pass++;
        bus.out_ready = 1'b1;
        wait_idle(50, ok);
        n_checks++;
        if (!ok) $display("FAIL single_drain: busy=%b pending=%0d", bus.busy, exp_pix.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int accepted;
        bit ok;
        unit_stall    = 1;
        unit_lat      = 2;
        bus.out_ready = 1'b0;
        accepted      = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_gx    = 11'($urandom_range(0, 2047));
        bus.in_gy    = 11'($urandom_range(0, 2047));
        for (int i = 0; i < 12; i++) begin
            if (bus.in_ready) accepted++;
            @(negedge clk);
            bus.in_gx = 11'($urandom_range(0, 2047));
            bus.in_gy = 11'($urandom_range(0, 2047));
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (accepted !== DEPTH + 1 || bus.in_ready !== 1'b0)
            $display("FAIL fill_count: accepted=%0d in_ready=%b, expected %0d and 0", accepted, bus.in_ready, DEPTH + 1);
        else n_pass++;
        unit_stall    = 0;
        bus.out_ready = 1'b1;
        wait_idle(300, ok);
        n_checks++;
        if (!ok) $display("FAIL fill_drain: busy=%b pending=%0d", bus.busy, exp_pix.size());
        else n_pass++;
    endtask

    task automatic test_hold();
        bit ok;
        int acc;
        int s0;
        int h;
        logic [7:0] pix;
        unit_lat      = 3;
        bus.out_ready = 1'b0;
        push(11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)), acc, ok);
        push(11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)), acc, ok);
        for (int i = 0; i < 50 && !bus.out_valid; i++) @(negedge clk);
        pix = bus.out_pixel;
        s0  = start_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_pixel !== pix)
                $display("FAIL hold_stable: out_valid=%b pixel=%0d, expected 1 and %0d", bus.out_valid, bus.out_pixel, pix);
            else n_pass++;
        end
        n_checks++;
        if (start_cnt !== s0) $display("FAIL hold_no_launch: %0d starts while held, expected 0", start_cnt - s0);
        else n_pass++;
        h = cyc;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && start_cnt == s0; i++) @(negedge clk);
        n_checks++;
        if (last_start_cyc !== h + 2) $display("FAIL hold_relaunch: start at %0d, expected %0d", last_start_cyc, h + 2);
        else n_pass++;
        wait_idle(100, ok);
        n_checks++;
        if (!ok) $display("FAIL hold_drain: busy=%b pending=%0d", bus.busy, exp_pix.size());
        else n_pass++;
    endtask

    task automatic test_extremes();
        bit ok;
        int acc;
        unit_lat      = 2;
        bus.out_ready = 1'b1;
        pix_log.delete();
        push(-11'sd1020, -11'sd1020, acc, ok);
        push(11'sd0, 11'sd0, acc, ok);
        wait_idle(100, ok);
        n_checks++;
        if (!ok || pix_log.size() != 2) $display("FAIL extreme_count: got %0d pixels, expected 2", pix_log.size());
        else if (pix_log[0] !== 8'd255 || pix_log[1] !== 8'd0)
            $display("FAIL extreme_values: got %0d,%0d expected 255,0", pix_log[0], pix_log[1]);
        else n_pass++;
    endtask

    task automatic test_random();
        bit ok;
        int base;
        unit_lat    = 0;
        pushes_done = 0;
        base        = n_out;
        fork
            begin
                int acc;
                bit pok;
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    push(11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)), acc, pok);
                end
                pushes_done = 1;
            end
            begin
                for (int i = 0; i < 4000 && !(pushes_done && exp_pix.size() == 0); i++) begin
                    @(negedge clk);
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_idle(500, ok);
        n_checks++;
        if (!ok || n_out - base !== 30) $display("FAIL random_count: got %0d pixels, expected 30", n_out - base);
        else n_pass++;
    endtask

`ifdef MAG_WATCHDOG_EN
    task automatic test_watchdog();
        bit ok;
        int acc;
        unit_lat      = 3;
        bus.out_ready = 1'b1;
        pix_log.delete();
        force_timeout = 1;
        push(11'sd6, 11'sd8, acc, ok);
        push(11'sd5, 11'sd12, acc, ok);
        wait_idle(400, ok);
        n_checks++;
        if (!ok || pix_log.size() != 2 || bus.timeout_err !== 1'b1)
            $display("FAIL watchdog: drained=%0d pixels=%0d timeout_err=%b, expected 1 2 1", ok, pix_log.size(), bus.timeout_err);
        else if (pix_log[0] !== 8'hFF || pix_log[1] !== 8'd13)
            $display("FAIL watchdog_pixels: got %0d,%0d expected 255,13", pix_log[0], pix_log[1]);
        else n_pass++;
    endtask
`endif

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        int acc;
        int s0;
        unit_stall    = 1;
        bus.out_ready = 1'b0;
        seen          = 0;
        push(11'sd100, -11'sd7, acc, ok);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.mag_start) begin
                seen = 1;
                break;
            end
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (!seen || bus.mag_start !== 1'b0) $display("FAIL reset_start_drop: start seen=%0d mag_start=%b, expected 1 and 0", seen, bus.mag_start);
        else n_pass++;
        repeat (2) @(negedge clk);
        exp_pix.delete(); exp_a.delete(); exp_b.delete();
        reset = 1'b0;
        s0 = start_cnt;
        push(-11'sd300, 11'sd400, acc, ok);
        push(11'sd9, 11'sd9, acc, ok);
        for (int i = 0; i < 20 && start_cnt == s0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        exp_pix.delete(); exp_a.delete(); exp_b.delete();
        reset      = 1'b0;
        stray_done = 1;
        s0         = start_cnt;
        repeat (5) @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_pixel !== 8'h00 ||
            bus.mag_a !== 11'sd0 || bus.mag_b !== 11'sd0 || bus.mag_start !== 1'b0 || start_cnt !== s0)
            $display("FAIL reset_mid: out_valid=%b busy=%b in_ready=%b pixel=%0d a=%0d b=%0d starts=%0d, expected 0 0 1 0 0 0 0",
                     bus.out_valid, bus.busy, bus.in_ready, bus.out_pixel, bus.mag_a, bus.mag_b, start_cnt - s0);
        else n_pass++;
`ifdef MAG_WATCHDOG_EN
        n_checks++;
        if (bus.timeout_err !== 1'b0) $display("FAIL reset_timeout_err: got %b expected 0", bus.timeout_err);
        else n_pass++;
`endif
        unit_stall    = 0;
        unit_lat      = 4;
        bus.out_ready = 1'b1;
        pix_log.delete();
        push(11'sd3, 11'sd4, acc, ok);
        wait_idle(60, ok);
        n_checks++;
        if (!ok || pix_log.size() != 1 || pix_log[0] !== 8'd5) $display("FAIL reset_recover: drained=%0d pixels=%0d", ok, pix_log.size());
        else n_pass++;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_gx     = '0;
        bus.in_gy     = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_extremes();
        test_random();
`ifdef MAG_WATCHDOG_EN
        test_watchdog();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "global timeout");
    end
endmodule
